ram_fifo_ctrl: RTL

- Pointer, flag and arbitration controller for the team's simple dual-port RAM; together they form a synchronous FIFO.
- Sits directly upstream of the RAM and drives its `rw`, `w_addr` and `r_addr` pins. Data moves RAM-side: `indata` comes straight from the producer and `outdata` goes straight to the consumer.
- The RAM has a single `rw` pin, so the block grants at most one operation (write or read) per cycle and arbitrates between simultaneous requests.

---
 rtl/ram_fifo_ctrl_if.sv | 29 ++
 rtl/ram_fifo_ctrl.sv | 102 ++++++++++
 2 files changed

// File: rtl/ram_fifo_ctrl_if.sv
// ram_fifo_ctrl_if: request/grant, RAM address and status bundle for ram_fifo_ctrl.
// master = producer/consumer side (drives requests), slave = the controller.
interface ram_fifo_ctrl_if #(
  parameter int locations = 8
) ();
  localparam int AW = $clog2(locations);
  localparam int CW = $clog2(locations + 1);

  logic          wr_req;
  logic          wr_ack;
  logic          rd_req;
  logic          rd_ack;
  logic          rw;
  logic [AW-1:0] w_addr;
  logic [AW-1:0] r_addr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  modport master (
    output wr_req, rd_req,
    input  wr_ack, rd_ack, rw, w_addr, r_addr, count, full, empty
  );

  modport slave (
    input  wr_req, rd_req,
    output wr_ack, rd_ack, rw, w_addr, r_addr, count, full, empty
  );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: pointer, flag and arbitration controller for a simple
// dual-port RAM with a single rw pin, forming a synchronous FIFO.
// Grants at most one operation (push or pop) per cycle.
// Optional feature macro: RAM_FIFO_CTRL_FAIR_ARB_EN
//   defined   -> round-robin arbitration on push/pop conflicts (prio register)
//   undefined -> a conflict always grants the push
module ram_fifo_ctrl #(
  parameter int locations = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  ram_fifo_ctrl_if.slave  bus
);
  localparam int AW = $clog2(locations);
  localparam int CW = $clog2(locations + 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(locations - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(locations);

  logic [AW-1:0] w_addr_q, w_addr_d;
  logic [AW-1:0] r_addr_q, r_addr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_s, empty_s;
  logic          we, re;
  logic          wr_ack, rd_ack;

`ifdef RAM_FIFO_CTRL_FAIR_ARB_EN
  logic prio_q, prio_d;   // 0 = push wins next conflict, 1 = pop wins
`endif

  // Flags decode from the occupancy count, never from pointer comparison.
  assign full_s  = (count_q == FULL_CNT);
  assign empty_s = (count_q == '0);
  assign we      = bus.wr_req & ~full_s;
  assign re      = bus.rd_req & ~empty_s;

  // Grant at most one eligible request; both acks are held low during reset.
  always_comb begin
    wr_ack = 1'b0;
    rd_ack = 1'b0;
`ifdef RAM_FIFO_CTRL_FAIR_ARB_EN
    prio_d = prio_q;
`endif
    if (rst_n) begin
      if (we && re) begin
`ifdef RAM_FIFO_CTRL_FAIR_ARB_EN
        wr_ack = ~prio_q;
        rd_ack = prio_q;
        prio_d = ~prio_q;
`else
        wr_ack = 1'b1;
`endif
      end else begin
        wr_ack = we;
        rd_ack = re;
      end
    end
  end

  // Next pointers and count; wrap is explicit so any depth works.
  always_comb begin
    w_addr_d = w_addr_q;
    r_addr_d = r_addr_q;
    count_d  = count_q;
    if (wr_ack) begin
      w_addr_d = (w_addr_q == LAST_ADDR) ? '0 : w_addr_q + AW'(1);
      count_d  = count_q + CW'(1);
    end else if (rd_ack) begin
      r_addr_d = (r_addr_q == LAST_ADDR) ? '0 : r_addr_q + AW'(1);
      count_d  = count_q - CW'(1);
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_addr_q <= '0;
      r_addr_q <= '0;
      count_q  <= '0;
    end else begin
      w_addr_q <= w_addr_d;
      r_addr_q <= r_addr_d;
      count_q  <= count_d;
    end
  end

`ifdef RAM_FIFO_CTRL_FAIR_ARB_EN
  // Round-robin priority flips only after a conflict grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prio_q <= 1'b0;
    else        prio_q <= prio_d;
  end
`endif

  assign bus.wr_ack = wr_ack;
  assign bus.rd_ack = rd_ack;
  assign bus.rw     = wr_ack;
  assign bus.w_addr = w_addr_q;
  assign bus.r_addr = r_addr_q;
  assign bus.count  = count_q;
  assign bus.full   = full_s;
  assign bus.empty  = empty_s;
endmodule
